tensorcore_feeder: RTL and testbench
====================================

# tensorcore_feeder

Stream-side initiator for the `tensorcore` 4x8·8x4+4x4 FP8/FP16 MMA unit. It accepts operand tiles A (fp8), B (fp8) and C (fp16) over a 16-bit valid/ready input stream and assembles them into the tensorcore's parallel operand ports. It issues a single-cycle `in_valid`, waits for `out_valid`, then serializes the 4x4 fp16 result D onto a 16-bit valid/ready output stream. It sits between the DMA/operand buffers and the tensorcore and handles the sequencing the tensorcore itself lacks.

## Interface
- `TIMEOUT`, default 255: WAIT-state cycles allowed before the result is abandoned (1..65535).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `e5m2mode_in`  in  1  FP8 format select, sampled with operand beat 0.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  operand beat accepted when `s_valid & s_ready`.
- `s_data`  in  16  operand beat payload.
- `tc_e5m2mode`  out  1  to tensorcore `e5m2mode`.
- `tc_in_valid`  out  1  to tensorcore `in_valid`.
- `tc_a`  out  8 x [0:3][0:7]  to tensorcore `a`.
- `tc_b`  out  8 x [0:7][0:3]  to tensorcore `b`.
- `tc_c`  out  16 x [0:3][0:3]  to tensorcore `c`.
- `tc_d`  in  16 x [0:3][0:3]  from tensorcore `d`.
- `tc_out_valid`  in  1  from tensorcore `out_valid`.
- `m_valid`  out  1  result beat valid.
- `m_ready`  in  1  result beat accepted when `m_valid & m_ready`.
- `m_data`  out  16  result beat payload (one fp16).
- `m_last`  out  1  high on the final result beat (beat 15).
- `busy`  out  1  high in ISSUE, WAIT and DRAIN.
- `timeout_err`  out  1  sticky; set on timeout.
- `err_clr`  in  1  synchronous clear of `timeout_err`.

## Operation
- FSM states: LOAD, ISSUE, WAIT, DRAIN. The reset state is LOAD.
- LOAD:
  - `s_ready=1`. A 6-bit beat counter counts accepted beats 0..47.
  - Beats 0–15 fill A row-major: beat k writes `a[k/4][2(k%4)]` from `s_data[7:0]` and `a[k/4][2(k%4)+1]` from `s_data[15:8]`.
  - Beats 16–31 fill B row-major: beat 16+k writes `b[k/2][2(k%2)]` from `[7:0]` and `b[k/2][2(k%2)+1]` from `[15:8]`.
  - Beats 32–47 fill C: beat 32+k writes `c[k/4][k%4]`.
  - `e5m2mode_in` is captured into `tc_e5m2mode` on acceptance of beat 0.
  - Acceptance of beat 47 moves to ISSUE.
- ISSUE: `tc_in_valid=1` for exactly one cycle; `s_ready=0`. Next state is WAIT.
- WAIT:
  - A 16-bit wait counter is cleared on entry and increments each cycle.
  - If `tc_out_valid=1`, `tc_d` is captured into the 16-entry result register and the next state is DRAIN.
  - Else, if the counter equals `TIMEOUT`, `timeout_err` is set, the result is discarded, and the next state is LOAD.
- DRAIN:
  - `m_valid=1`. `m_data` is result entry r, row-major (`d[r/4][r%4]`). `m_last = (r==15)`.
  - r advances on each `m_valid & m_ready`.
  - Acceptance of beat 15 returns to LOAD.
- Operand registers (`tc_a`, `tc_b`, `tc_c`, `tc_e5m2mode`) are held unchanged from ISSUE until DRAIN is entered or a timeout occurs. The tensorcore consumes `c` late in its pipeline, so this hold is required.
- `tc_out_valid` outside WAIT is ignored. It does not corrupt the result register or change state.
- `err_clr` clears `timeout_err`. A timeout in the same cycle as `err_clr` wins, and the flag stays set.
- The output stream holds `m_data`/`m_last` stable while `m_valid & ~m_ready`.

## Timing
- Reset (async assert, `rst=0`): state LOAD, all counters 0, and all outputs 0: `s_ready`, `tc_*`, `m_valid`, `m_data`, `m_last`, `busy`, `timeout_err`. Operand and result registers are 0.
- First rising edge after `rst` deasserts: `s_ready=1`.
- Reset mid-operation aborts immediately. `m_valid` and `tc_in_valid` drop asynchronously, and the partial tile is lost.
- Beat 47 accepted at edge N: ISSUE during cycle N..N+1 (`tc_in_valid=1`), WAIT from edge N+1.
- `tc_out_valid` sampled high at edge M: `m_valid=1` with `d[0][0]` from edge M.
- Back-to-back: the edge that accepts result beat 15 makes `s_ready=1` in the following cycle.
- Minimum tile period is 48 + 1 + tensorcore latency + 16 cycles.
- Timeout: with no `tc_out_valid`, `timeout_err` rises TIMEOUT+1 edges after WAIT entry, and `s_ready` rises in the same cycle.

## Test plan
- **Identity tile.** Stimulus: A all 0x38 (E4M3 1.0), B all 0x38, C all 0x0000, `e5m2mode_in=0`, with a behavioural tensorcore model. Required: one `tc_in_valid` pulse; 16 result beats of fp16 8.0 (0x4800); `m_last` only on beat 15.
- **Packing order.** Stimulus: A and B loaded with distinct byte indices 0..63. Required: while in WAIT, `tc_a[i][j]` and `tc_b[j][k]` match the mapping in Operation; `tc_c[3][3]` equals beat 47.
- **Backpressure.** Stimulus: `s_valid` toggling randomly during load; `m_ready` low for 5 cycles on beat 7. Required: no beat lost or duplicated; `m_data` held stable while stalled; exactly 16 output beats.
- **Timeout.** Stimulus: `TIMEOUT=10` and the model never asserts `tc_out_valid`. Required: `timeout_err=1` and `s_ready=1` 11 edges after WAIT entry; no `m_valid`; `err_clr` then clears the flag.
- **Spurious and late valid.** Stimulus: `tc_out_valid` pulsed during LOAD and during DRAIN. Required: no state change and result beats unchanged.
- **Reset mid-DRAIN.** Stimulus: `rst=0` at result beat 5. Required: `m_valid=0` immediately; after release, the next 48 beats form a fresh tile with correct output.

Source files
------------

// File: rtl/tensorcore_feeder.sv
// tensorcore_feeder
//   Assembles fp8 A/B and fp16 C operand tiles from a 16-bit valid/ready
//   stream into the tensorcore's parallel operand ports. It pulses in_valid
//   once, waits (bounded by TIMEOUT) for out_valid, and then serializes the
//   4x4 fp16 result onto a 16-bit valid/ready output stream.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   e5m2mode_in              FP8 format select, captured with operand beat 0
//   s_valid/s_ready/s_data   48-beat operand stream (A: 0-15, B: 16-31, C: 32-47)
//   tc_e5m2mode, tc_in_valid, tc_a, tc_b, tc_c   operands to the tensorcore
//   tc_d, tc_out_valid       result from the tensorcore
//   m_valid/m_ready/m_data/m_last   16-beat result stream, row-major
//   busy                     high outside LOAD
//   timeout_err, err_clr     sticky timeout flag and its synchronous clear
module tensorcore_feeder #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    e5m2mode_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [15:0]             s_data,
  output logic                    tc_e5m2mode,
  output logic                    tc_in_valid,
  output logic [0:3][0:7][7:0]    tc_a,
  output logic [0:7][0:3][7:0]    tc_b,
  output logic [0:3][0:3][15:0]   tc_c,
  input  logic [0:3][0:3][15:0]   tc_d,
  input  logic                    tc_out_valid,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  beat_q, beat_d;
  logic [15:0] wait_q, wait_d;
  logic [3:0]  r_q, r_d;
  logic        err_q, err_d;
  // Low only until the first edge after reset release, so s_ready stays 0 in reset.
  logic        run_q;

  logic [0:3][0:7][7:0]  a_q;
  logic [0:7][0:3][7:0]  b_q;
  logic [0:3][0:3][15:0] c_q;
  logic [0:3][0:3][15:0] d_q;
  logic                  e5_q;

  logic s_fire, m_fire, timeout_hit;

  assign s_ready     = run_q && (state_q == ST_LOAD);
  assign tc_in_valid = (state_q == ST_ISSUE);
  assign m_valid     = (state_q == ST_DRAIN);
  assign busy        = (state_q != ST_LOAD);
  assign m_data      = d_q[r_q[3:2]][r_q[1:0]];
  assign m_last      = m_valid && (r_q == 4'd15);
  assign timeout_err = err_q;
  assign tc_a        = a_q;
  assign tc_b        = b_q;
  assign tc_c        = c_q;
  assign tc_e5m2mode = e5_q;

  assign s_fire      = s_valid && s_ready;
  assign m_fire      = m_valid && m_ready;
  // out_valid has priority: a result arriving on the timeout cycle is kept.
  assign timeout_hit = (state_q == ST_WAIT) && !tc_out_valid && (wait_q == TIMEOUT);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    r_d     = r_q;
    unique case (state_q)
      ST_LOAD: begin
        if (s_fire) begin
          if (beat_q == 6'd47) begin
            beat_d  = 6'd0;
            state_d = ST_ISSUE;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      ST_ISSUE: begin
        wait_d  = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tc_out_valid) begin
          r_d     = 4'd0;
          state_d = ST_DRAIN;
        end else if (timeout_hit) begin
          state_d = ST_LOAD;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        if (m_fire) begin
          r_d = r_q + 4'd1;
          if (r_q == 4'd15) state_d = ST_LOAD;
        end
      end
    endcase
    // A timeout on the same edge as err_clr leaves the flag set.
    if (timeout_hit)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      beat_q  <= 6'd0;
      wait_q  <= 16'd0;
      r_q     <= 4'd0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      r_q     <= r_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  // Operand registers are written only in LOAD, so they stay put through
  // ISSUE and WAIT while the tensorcore still reads c late in its pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these tile registers are reset because the port values must read zero in reset.
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      e5_q <= 1'b0;
    end else begin
      if (s_fire) begin
        case (beat_q[5:4])
          2'b00: begin
            a_q[beat_q[3:2]][{beat_q[1:0], 1'b0}] <= s_data[7:0];
            a_q[beat_q[3:2]][{beat_q[1:0], 1'b1}] <= s_data[15:8];
          end
          2'b01: begin
            b_q[beat_q[3:1]][{beat_q[0], 1'b0}] <= s_data[7:0];
            b_q[beat_q[3:1]][{beat_q[0], 1'b1}] <= s_data[15:8];
          end
          default: c_q[beat_q[3:2]][beat_q[1:0]] <= s_data;
        endcase
        if (beat_q == 6'd0) e5_q <= e5m2mode_in;
      end
      if ((state_q == ST_WAIT) && tc_out_valid) d_q <= tc_d;
    end
  end

endmodule

// File: tb/tb_tensorcore_feeder.sv
// tb_tensorcore_feeder
//   Directed bench for tensorcore_feeder. The tensorcore is stood in for by a
//   behavioural MMA computed from the operand ports; expected result beats are
//   computed from the bench's own stimulus tiles and queued on send.
module tb_tensorcore_feeder;

  typedef logic [0:3][0:7][7:0]  a_t;
  typedef logic [0:7][0:3][7:0]  b_t;
  typedef logic [0:3][0:3][15:0] d_t;

  localparam logic [15:0] TO = 16'd10;
  localparam d_t GARBAGE = {16{16'hDEAD}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic e5m2mode_in = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic tc_out_valid = 1'b0, err_clr = 1'b0;
  logic [15:0] s_data = 16'd0;
  d_t tc_d = GARBAGE;
  logic s_ready, tc_e5m2mode, tc_in_valid, m_valid, m_last, busy, timeout_err;
  a_t tc_a;
  b_t tc_b;
  d_t tc_c;
  logic [15:0] m_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  a_t sa;
  b_t sb;
  d_t sc;
  bit se5;

  tensorcore_feeder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .e5m2mode_in(e5m2mode_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tc_e5m2mode(tc_e5m2mode), .tc_in_valid(tc_in_valid),
    .tc_a(tc_a), .tc_b(tc_b), .tc_c(tc_c), .tc_d(tc_d), .tc_out_valid(tc_out_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_to_real(input logic [7:0] b, input bit e5);
    int e;
    real m, v;
    if (e5) begin
      e = int'(b[6:2]);
      m = real'(b[1:0]) / 4.0;
      v = (e == 0) ? m * pow2(-14) : (1.0 + m) * pow2(e - 15);
    end else begin
      e = int'(b[6:3]);
      m = real'(b[2:0]) / 8.0;
      v = (e == 0) ? m * pow2(-6) : (1.0 + m) * pow2(e - 7);
    end
    return b[7] ? -v : v;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int e;
    real m, v;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    v = (e == 0) ? m * pow2(-14) : (1.0 + m) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real x);
    logic s;
    int e, m;
    real v;
    s = (x < 0.0);
    v = s ? -x : x;
    if (v == 0.0) return {s, 15'd0};
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
    if (v < 1.0) begin
      m = $rtoi(v * 1024.0 + 0.5);
      return {s, 4'd0, m[10:0]};
    end
    m = $rtoi((v - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic d_t compute_d(input a_t a, input b_t b, input d_t c, input bit e5);
    d_t d;
    real acc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        acc = fp16_to_real(c[i][k]);
        for (int j = 0; j < 8; j++) acc = acc + fp8_to_real(a[i][j], e5) * fp8_to_real(b[j][k], e5);
        d[i][k] = real_to_fp16(acc);
      end
    return d;
  endfunction

  function automatic logic [15:0] beat_word(input int k);
    int q;
    if (k < 16) return {sa[k/4][2*(k%4)+1], sa[k/4][2*(k%4)]};
    if (k < 32) begin
      q = k - 16;
      return {sb[q/2][2*(q%2)+1], sb[q/2][2*(q%2)]};
    end
    q = k - 32;
    return sc[q/4][q%4];
  endfunction

  task automatic push_expected();
    d_t d;
    d = compute_d(sa, sb, sc, se5);
    for (int r = 0; r < 16; r++) exp_q.push_back(d[r/4][r%4]);
  endtask

  task automatic random_tile();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) begin
        sa[i][j] = 8'($urandom_range(0, 8'h5F)) | (8'($urandom_range(0, 1)) << 7);
        sb[j][i] = 8'($urandom_range(0, 8'h5F)) | (8'($urandom_range(0, 1)) << 7);
      end
    for (int i = 0; i < 16; i++)
      sc[i/4][i%4] = {1'b0, 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
    se5 = 1'b0;
  endtask

  // Drives the 48 operand beats; a beat counts once s_valid&s_ready holds for the next edge.
  task automatic send_tile(input bit gaps, input int spur_beat);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < 48 && guard < 1000) begin
      @(negedge clk);
      tc_out_valid = 1'b0;
      tc_d = GARBAGE;
      if (i == spur_beat) tc_out_valid = 1'b1;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = beat_word(i);
      e5m2mode_in = (i == 0) ? se5 : ~se5;
      if (s_valid && s_ready) i++;
      guard++;
    end
    check("load_beats", i, 48);
  endtask

  // Follows ISSUE and WAIT. resp_at = negedges after ISSUE at which the model
  // answers (0 = never). Returns at the negedge where m_valid is expected, or
  // one negedge after the timeout edge.
  task automatic run_core(input int resp_at, input bit pack_chk);
    bit seen, done;
    int j;
    seen = 1'b0;
    for (int g = 0; g < 8 && !seen; g++) begin
      @(negedge clk);
      s_valid = 1'b0;
      tc_out_valid = 1'b0;
      tc_d = GARBAGE;
      seen = tc_in_valid;
    end
    check("issue_pulse", tc_in_valid, 1);
    check("issue_busy", busy, 1);
    check("issue_sready", s_ready, 0);
    j = 0;
    done = 1'b0;
    while (!done && j < int'(TO) + 4) begin
      @(negedge clk);
      j++;
      tc_out_valid = 1'b0;
      tc_d = GARBAGE;
      err_clr = 1'b0;
      if (j == 1) begin
        check("single_pulse", tc_in_valid, 0);
        check("wait_busy", busy, 1);
        if (pack_chk) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) check("pack_a", tc_a[r][c], 8 * r + c);
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) check("pack_b", tc_b[r][c], 32 + 4 * r + c);
          check("pack_c33", tc_c[3][3], 16'h3C0F);
          check("pack_e5", tc_e5m2mode, se5);
        end
      end
      if (resp_at != 0 && j == resp_at + 1) begin
        check("resp_mvalid", m_valid, 1);
        check("resp_no_err", timeout_err, 0);
        done = 1'b1;
      end else if (resp_at == 0 && j == int'(TO) + 1) begin
        check("pre_timeout_err", timeout_err, 0);
        check("pre_timeout_sready", s_ready, 0);
        err_clr = 1'b1;
      end else if (resp_at == 0 && j == int'(TO) + 2) begin
        check("timeout_err", timeout_err, 1);
        check("timeout_sready", s_ready, 1);
        check("timeout_mvalid", m_valid, 0);
        done = 1'b1;
      end
      if (resp_at != 0 && j == resp_at) begin
        check("wait_mvalid", m_valid, 0);
        tc_d = compute_d(tc_a, tc_b, tc_c, tc_e5m2mode);
        tc_out_valid = 1'b1;
      end
    end
    check("core_done", done, 1);
  endtask

  // Consumes result beats against the scoreboard; optional stall, spurious out_valid, and reset abort.
  task automatic drain(input int stall_beat, input int stall_len, input int spur_beat, input int abort_beat);
    int beats, stalled, guard;
    logic [15:0] held, exp;
    bit aborted;
    beats = 0;
    stalled = 0;
    guard = 0;
    aborted = 1'b0;
    held = 16'd0;
    while (beats < 16 && guard < 200 && !aborted) begin
      tc_out_valid = 1'b0;
      tc_d = GARBAGE;
      m_ready = 1'b0;
      if (beats == abort_beat) begin
        rst = 1'b0;
        #1;
        check("rst_mvalid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sready", s_ready, 0);
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        check("drain_mvalid", m_valid, 1);
        if (beats == spur_beat) tc_out_valid = 1'b1;
        if (beats == stall_beat && stalled < stall_len) begin
          if (stalled == 0) held = m_data;
          else check("stall_hold", m_data, held);
          stalled++;
        end else begin
          m_ready = 1'b1;
          exp = 16'hxxxx;
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          check("d_beat", m_data, exp);
          check("m_last", m_last, beats == 15);
          beats++;
        end
        @(negedge clk);
        guard++;
      end
    end
    m_ready = 1'b0;
    tc_out_valid = 1'b0;
    if (!aborted) begin
      check("drain_beats", beats, 16);
      check("drain_done_mvalid", m_valid, 0);
      check("b2b_sready", s_ready, 1);
      check("sb_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_sready0", s_ready, 0);
    check("rst_in_valid0", tc_in_valid, 0);
    check("rst_mvalid0", m_valid, 0);
    check("rst_mdata0", m_data, 0);
    check("rst_mlast0", m_last, 0);
    check("rst_busy0", busy, 0);
    check("rst_err0", timeout_err, 0);
    check("rst_ops0", (tc_a == '0) && (tc_b == '0) && (tc_c == '0) && !tc_e5m2mode, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_sready0", s_ready, 0);
    @(negedge clk);
    check("release_sready1", s_ready, 1);

    // Identity tile: all-ones A and B, zero C -> every result is 8.0.
    for (int i = 0; i < 32; i++) begin
      sa[i/8][i%8] = 8'h38;
      sb[i/4][i%4] = 8'h38;
    end
    sc = '0;
    se5 = 1'b0;
    for (int r = 0; r < 16; r++) exp_q.push_back(16'h4800);
    send_tile(1'b0, -1);
    run_core(3, 1'b0);
    drain(-1, 0, -1, -1);

    // Packing order, E5M2 capture on beat 0, spurious out_valid in LOAD and DRAIN.
    for (int i = 0; i < 32; i++) begin
      sa[i/8][i%8] = 8'(i);
      sb[i/4][i%4] = 8'(32 + i);
    end
    for (int q = 0; q < 16; q++) sc[q/4][q%4] = 16'h3C00 + 16'(q);
    se5 = 1'b1;
    push_expected();
    send_tile(1'b0, 10);
    run_core(5, 1'b1);
    drain(-1, 0, 3, -1);

    // Backpressure on both streams; result arrives on the timeout cycle itself.
    random_tile();
    push_expected();
    send_tile(1'b1, -1);
    run_core(int'(TO) + 1, 1'b0);
    drain(7, 5, -1, -1);

    // Timeout with err_clr on the same edge, then a plain clear.
    random_tile();
    send_tile(1'b0, -1);
    run_core(0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", timeout_err, 0);
    check("after_to_sready", s_ready, 1);

    // Reset in the middle of DRAIN, then a fresh tile.
    random_tile();
    push_expected();
    send_tile(1'b0, -1);
    run_core(2, 1'b0);
    drain(-1, 0, -1, 5);
    @(negedge clk);
    check("rst_mid_mdata", m_data, 0);
    check("rst_mid_ops", (tc_a == '0) && (tc_b == '0) && (tc_c == '0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sready", s_ready, 1);
    random_tile();
    se5 = 1'b1;
    push_expected();
    send_tile(1'b1, -1);
    run_core(4, 1'b0);
    drain(2, 3, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
